burst_mode_ctrl: RTL and testbench

- Control FSM directly upstream of the burst-mode datapath; generates the 2-bit Mode code that the datapath decodes, plus all cellular-RAM strobes.
- After reset, waits out power-up, then performs one configuration-register (BCR) write with Mode=Con.
- Afterwards serves single-request fixed-length synchronous burst reads/writes with a word-level strobe handshake toward the client.

---
 rtl/burst_mode_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_burst_mode_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : burst_mode_ctrl
// Description : Control FSM for a cellular-RAM burst-mode datapath. After
//               reset it waits out memory power-up, performs one asynchronous
//               configuration-register (BCR) write, then serves fixed-length
//               synchronous burst reads/writes one request at a time.
// Ports       : Clk        - system clock (also forwarded as memory clock)
//               Reset      - asynchronous active-high reset
//               Start/RW   - burst request and direction (1=write), IDLE only
//               MemWait    - memory WAIT, high = no transfer this cycle
//               Mode       - datapath mode: 00 Idle, 01 Read, 10 Con, 11 Write
//               MemCE_n, MemOE_n, MemWE_n, MemADV_n, MemCRE, MemClkEn
//                          - cellular-RAM strobes
//               Ready      - high in IDLE; Start is accepted while high
//               WordStrobe - one pulse per word transferred
//               WordCount  - index of the current burst word
//               Done       - pulse on the final burst word / last config cycle
// Revision    : 1.0 - initial release
// ============================================================================
module burst_mode_ctrl #(
    parameter int PWRUP_CYCLES = 15000,
    parameter int CFG_CYCLES   = 8,
    parameter int LATENCY      = 3,
    parameter int BURST_LEN    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       RW,
    input  logic       MemWait,
    output logic [1:0] Mode,
    output logic       MemCE_n,
    output logic       MemOE_n,
    output logic       MemWE_n,
    output logic       MemADV_n,
    output logic       MemCRE,
    output logic       MemClkEn,
    output logic       Ready,
    output logic       WordStrobe,
    output logic [3:0] WordCount,
    output logic       Done
);

    // One shared counter times power-up, config and latency phases.
    localparam int c_CNT_MAX =
        (PWRUP_CYCLES > CFG_CYCLES) ?
            ((PWRUP_CYCLES > LATENCY) ? PWRUP_CYCLES : LATENCY) :
            ((CFG_CYCLES > LATENCY) ? CFG_CYCLES : LATENCY);
    localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PWRUP_LAST = c_CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CFG_LAST   = c_CNT_W'(CFG_CYCLES - 1);
    // ADDR already accounts for one latency cycle, LAT covers the rest.
    localparam logic [c_CNT_W-1:0] c_LAT_LAST   =
        c_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic               c_HAS_LAT    = (LATENCY >= 2);
    localparam logic [3:0]         c_LAST_WORD  = 4'(BURST_LEN - 1);

    localparam logic [1:0] c_MODE_IDLE  = 2'b00;
    localparam logic [1:0] c_MODE_READ  = 2'b01;
    localparam logic [1:0] c_MODE_CON   = 2'b10;
    localparam logic [1:0] c_MODE_WRITE = 2'b11;

    localparam logic [2:0] c_ST_PWRUP = 3'd0;
    localparam logic [2:0] c_ST_CFG   = 3'd1;
    localparam logic [2:0] c_ST_IDLE  = 3'd2;
    localparam logic [2:0] c_ST_ADDR  = 3'd3;
    localparam logic [2:0] c_ST_LAT   = 3'd4;
    localparam logic [2:0] c_ST_BURST = 3'd5;
    localparam logic [2:0] c_ST_RECOV = 3'd6;

    logic [2:0]         r_state, w_nextState;
    logic [c_CNT_W-1:0] r_cnt, w_nextCnt;
    logic               r_isWrite, w_nextIsWrite;

    logic [1:0] w_mode, w_rwMode;
    logic       w_ceN, w_oeN, w_weN, w_advN, w_cre, w_clkEn;
    logic       w_ready, w_wordStrobe, w_done;
    logic [3:0] w_wordCount;

    // State and output register. Outputs are computed for the state being
    // entered so every output is a flop aligned with its state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= c_ST_PWRUP;
            r_cnt      <= '0;
            r_isWrite  <= 1'b0;
            Mode       <= c_MODE_IDLE;
            MemCE_n    <= 1'b1;
            MemOE_n    <= 1'b1;
            MemWE_n    <= 1'b1;
            MemADV_n   <= 1'b1;
            MemCRE     <= 1'b0;
            MemClkEn   <= 1'b0;
            Ready      <= 1'b0;
            WordStrobe <= 1'b0;
            WordCount  <= 4'd0;
            Done       <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_nextCnt;
            r_isWrite  <= w_nextIsWrite;
            Mode       <= w_mode;
            MemCE_n    <= w_ceN;
            MemOE_n    <= w_oeN;
            MemWE_n    <= w_weN;
            MemADV_n   <= w_advN;
            MemCRE     <= w_cre;
            MemClkEn   <= w_clkEn;
            Ready      <= w_ready;
            WordStrobe <= w_wordStrobe;
            WordCount  <= w_wordCount;
            Done       <= w_done;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_cnt;
        w_nextIsWrite = r_isWrite;
        case (r_state)
            c_ST_PWRUP: begin
                if (r_cnt == c_PWRUP_LAST) begin
                    w_nextState = c_ST_CFG;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_ST_CFG: begin
                if (r_cnt == c_CFG_LAST) begin
                    w_nextState = c_ST_IDLE;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_ST_IDLE: begin
                if (Start) begin
                    w_nextState   = c_ST_ADDR;
                    w_nextIsWrite = RW;
                end
            end
            c_ST_ADDR: begin
                w_nextCnt   = '0;
                w_nextState = c_HAS_LAT ? c_ST_LAT : c_ST_BURST;
            end
            c_ST_LAT: begin
                if (r_cnt == c_LAT_LAST) begin
                    w_nextState = c_ST_BURST;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_ST_BURST: begin
                // Done is only raised on the strobe of the final word.
                if (Done) begin
                    w_nextState = c_ST_RECOV;
                end
            end
            c_ST_RECOV: w_nextState = c_ST_IDLE;
            default:    w_nextState = c_ST_PWRUP;
        endcase
    end

    // Output logic for the state about to be entered.
    always_comb begin
        w_mode       = c_MODE_IDLE;
        w_ceN        = 1'b1;
        w_oeN        = 1'b1;
        w_weN        = 1'b1;
        w_advN       = 1'b1;
        w_cre        = 1'b0;
        w_clkEn      = 1'b0;
        w_ready      = 1'b0;
        w_wordStrobe = 1'b0;
        w_wordCount  = 4'd0;
        w_done       = 1'b0;
        w_rwMode     = w_nextIsWrite ? c_MODE_WRITE : c_MODE_READ;
        case (w_nextState)
            c_ST_CFG: begin
                w_mode = c_MODE_CON;
                w_cre  = 1'b1;
                w_ceN  = 1'b0;
                w_weN  = 1'b0;
                w_advN = (w_nextCnt != '0);
                w_done = (w_nextCnt == c_CFG_LAST);
            end
            c_ST_IDLE: w_ready = 1'b1;
            c_ST_ADDR: begin
                w_mode  = w_rwMode;
                w_ceN   = 1'b0;
                w_advN  = 1'b0;
                w_clkEn = 1'b1;
                w_weN   = ~w_nextIsWrite;
            end
            c_ST_LAT, c_ST_BURST: begin
                w_mode  = w_rwMode;
                w_ceN   = 1'b0;
                w_clkEn = 1'b1;
                w_weN   = ~w_nextIsWrite;
                w_oeN   = w_nextIsWrite;
                if (w_nextState == c_ST_BURST) begin
                    w_wordStrobe = ~MemWait;
                    // Word index advances the cycle after each transfer.
                    w_wordCount  = (r_state == c_ST_BURST) ?
                                   (WordCount + {3'b000, WordStrobe}) : 4'd0;
                    w_done       = w_wordStrobe && (w_wordCount == c_LAST_WORD);
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_mode_ctrl
// Description : Self-checking bench for burst_mode_ctrl. A timeline model
//               derives the expected output vector of every cycle from edge
//               counts since reset and since the accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_mode_ctrl;

    localparam int PW   = 20;
    localparam int CFGC = 8;
    localparam int LAT  = 3;
    localparam int BL   = 4;

    logic       Clk = 1'b0;
    logic       Reset, Start, RW, MemWait;
    logic [1:0] Mode;
    logic       MemCE_n, MemOE_n, MemWE_n, MemADV_n, MemCRE, MemClkEn;
    logic       Ready, WordStrobe, Done;
    logic [3:0] WordCount;
    logic [15:0] obs;

    always #5 Clk = ~Clk;

    burst_mode_ctrl #(
        .PWRUP_CYCLES(PW),
        .CFG_CYCLES  (CFGC),
        .LATENCY     (LAT),
        .BURST_LEN   (BL)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .RW        (RW),
        .MemWait   (MemWait),
        .Mode      (Mode),
        .MemCE_n   (MemCE_n),
        .MemOE_n   (MemOE_n),
        .MemWE_n   (MemWE_n),
        .MemADV_n  (MemADV_n),
        .MemCRE    (MemCRE),
        .MemClkEn  (MemClkEn),
        .Ready     (Ready),
        .WordStrobe(WordStrobe),
        .WordCount (WordCount),
        .Done      (Done)
    );

    assign obs = {1'b0, Mode, MemCE_n, MemOE_n, MemWE_n, MemADV_n, MemCRE,
                  MemClkEn, Ready, WordStrobe, WordCount, Done};

    int checks   = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mkVec(
        input logic [1:0] md, input logic ce, input logic oe, input logic we,
        input logic adv, input logic cre, input logic ck, input logic rdy,
        input logic stb, input logic [3:0] wc, input logic dn);
        return {1'b0, md, ce, oe, we, adv, cre, ck, rdy, stb, wc, dn};
    endfunction

    function automatic logic [15:0] inactiveVec();
        return mkVec(2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                     4'd0, 1'b0);
    endfunction

    // Timeline model state.
    int          e;          // clock edges since reset release
    bit          busy;       // a request has been accepted
    int          addrE;      // edge at which the address cycle began
    int          words;      // words transferred so far in this burst
    bit          isWr;
    bit          eReady, eDone, inBurst;
    int          eWc;
    int          strobeCnt;
    logic [15:0] expVec;

    task automatic modelReset();
        e = 0; busy = 0; words = 0; isWr = 0;
        eReady = 0; eDone = 0; inBurst = 0; eWc = 0; strobeCnt = 0;
        expVec = inactiveVec();
    endtask

    task automatic modelStep(input bit st, input bit rw, input bit mw);
        bit         prevReady, prevDone, stb;
        int         d;
        logic [1:0] md;
        prevReady = eReady;
        prevDone  = eDone;
        e++;
        eReady = 0; eDone = 0; eWc = 0; inBurst = 0;
        md = isWr ? 2'b11 : 2'b01;
        if (e < PW) begin
            expVec = inactiveVec();
        end else if (e < PW + CFGC) begin
            d = e - PW;
            eDone = (d == CFGC - 1);
            expVec = mkVec(2'b10, 1'b0, 1'b1, 1'b0, (d != 0), 1'b1, 1'b0,
                           1'b0, 1'b0, 4'd0, eDone);
        end else if (busy) begin
            if (prevDone) begin
                busy = 0;
                expVec = inactiveVec();
            end else begin
                d = e - addrE;
                if (d < LAT) begin
                    expVec = mkVec(md, 1'b0, isWr, !isWr, 1'b1, 1'b0, 1'b1,
                                   1'b0, 1'b0, 4'd0, 1'b0);
                end else begin
                    stb = !mw;
                    inBurst = 1;
                    eWc = words;
                    eDone = stb && (words == BL - 1);
                    if (stb) words++;
                    expVec = mkVec(md, 1'b0, isWr, !isWr, 1'b1, 1'b0, 1'b1,
                                   1'b0, stb, 4'(eWc), eDone);
                end
            end
        end else if (prevReady && st) begin
            busy = 1; addrE = e; isWr = rw; words = 0; strobeCnt = 0;
            md = isWr ? 2'b11 : 2'b01;
            expVec = mkVec(md, 1'b0, 1'b1, !isWr, 1'b0, 1'b0, 1'b1, 1'b0,
                           1'b0, 4'd0, 1'b0);
        end else begin
            eReady = 1;
            expVec = mkVec(2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                           1'b0, 4'd0, 1'b0);
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit st, input bit rw, input bit mw);
        Start = st; RW = rw; MemWait = mw;
        @(posedge Clk);
        modelStep(st, rw, mw);
        @(negedge Clk);
        checkVal($sformatf("outputs@edge%0d", e), obs, expVec);
        if (inBurst && WordStrobe) strobeCnt++;
        if (inBurst && eDone) begin
            checkVal("strobes_per_burst", 16'(strobeCnt), 16'(BL));
            strobeCnt = 0;
        end
    endtask

    task automatic randCycles(input int n, input bit useWait);
        for (int i = 0; i < n; i++) begin
            cycle(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  useWait && ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        Reset = 1'b1; Start = 1'b0; RW = 1'b0; MemWait = 1'b0;
        modelReset();
        repeat (3) @(negedge Clk);
        checkVal("reset_state", obs, inactiveVec());
        Reset = 1'b0;

        // Power-up and config with Start noise that must be ignored.
        randCycles(PW + CFGC, 1'b0);

        // Directed read, no wait states.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (9) cycle(1'b0, 1'b0, 1'b0);

        // Directed write with two wait cycles at word 1, Start pulsed in LAT.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back bursts.
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);

        // Fully random traffic with wait states.
        randCycles(300, 1'b1);

        // Reset in the middle of a read at word 2.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (inBurst && eWc == 2) begin
                found = 1;
                break;
            end
        end
        checkVal("reach_word2", 16'(found), 16'd1);
        #2 Reset = 1'b1;
        #1 checkVal("async_reset", obs, inactiveVec());
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        checkVal("reset_held", obs, inactiveVec());
        Reset = 1'b0;
        modelReset();

        // Power-up and config must repeat before traffic resumes.
        randCycles(PW + CFGC + 2, 1'b0);
        randCycles(150, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
